ring_buffer_checker: RTL and testbench
======================================

// Module: ring_buffer_checker
// PURPOSE
// - Synthesizable, parametrised successor to the ring buffer monitor. Sits beside the ring buffer in the top level.
// - Shadows every strobed write into a DEPTH x WIDTH model.
// - Checks each read (readPtr change -> dout one clk later) against that model.
// - Reports pass/fail through registered status outputs instead of $display.
// PARAMETERS
// - WIDTH      16             data width of din/dout
// - DEPTH      8              ring buffer entries; power of 2, >= 2
// - PTR_W      $clog2(DEPTH)  readPtr width (derived, do not override)
// - ERR_W      8              err_count width; counter saturates
// PORTS
// - clk         in   1        single clock, rising edge
// - reset       in   1        synchronous, active-high
// - listen      in   1        arm capture (level)
// - strobe      in   1        write strobe; sampled on clk, rising edge = write
// - din         in   WIDTH    write data, valid in strobe-rise cycle
// - readPtr     in   PTR_W    DUT read pointer
// - dout        in   WIDTH    DUT read data, valid 1 clk after readPtr changes
// - state_o     out  2        current FSM state (enum from package)
// - wr_count    out  PTR_W+1  entries captured since last arm, 0..DEPTH
// - buf_full    out  1        wr_count == DEPTH
// - mismatch    out  1        1-clk pulse on failed compare
// - err_count   out  ERR_W    saturating mismatch count
// - err_ptr     out  PTR_W    readPtr of most recent mismatch
// - err_exp     out  WIDTH    expected data of most recent mismatch
// - err_act     out  WIDTH    actual dout of most recent mismatch
// - overflow    out  1        sticky; strobe seen while FULL/CHECK
// BEHAVIOUR
// - Reset: every output 0; state IDLE; strobe_q 0; readPtr_q 0; cmp_pend 0. Shadow contents are don't-care.
// - Reset mid-operation aborts any capture or pending compare; mismatch is not pulsed.
// - strobe_rise = strobe & ~strobe_q. rdchg = (readPtr != readPtr_q) & ~reset.
// - readPtr_q updates every cycle.
// - IDLE: listen=1 -> ARMED; wr_count cleared.
// - ARMED / CAPTURE:
//   - strobe_rise writes din to shadow[wr_count[PTR_W-1:0]] and increments wr_count; ARMED -> CAPTURE.
//   - The DEPTH-th write goes to FULL the next cycle.
//   - readPtr changes are ignored in these states.
// - FULL: the first rdchg moves to CHECK and also schedules a compare.
// - CHECK: each rdchg sets cmp_pend and latches cmp_ptr = readPtr.
// - Compare in the cycle after rdchg:
//   - if dout != shadow[cmp_ptr]: pulse mismatch, load err_ptr/err_exp/err_act, err_count += 1 (saturate at 2^ERR_W-1).
// - Back-to-back readPtr changes give one compare per cycle (1-stage pipeline); no compare is dropped.
// - strobe_rise in FULL/CHECK: set overflow; shadow and wr_count unchanged.
// - listen rising edge in FULL/CHECK: restart capture.
//   - -> ARMED; wr_count=0.
//   - A compare pending in that cycle still completes.
//   - err_count, err_*, overflow are retained; only reset clears them.
// - Simultaneous strobe_rise and listen rise in FULL/CHECK: restart wins; that strobe is captured as entry 0.
// - listen deassert does not change state.
// - wr_count wraps never: max DEPTH, then overflow path.
// STRUCTURE
// - Package ring_buffer_checker_pkg holds:
//   - typedef enum logic [1:0] {IDLE, ARMED_CAP, FULL, CHECK} rbc_state_t (ARMED/CAPTURE share one encoding, distinguished by wr_count==0);
//   - localparam ERR_SAT.
// - Sub-module rbc_shadow_mem: DEPTH x WIDTH register array, 1 sync write port, 1 async read port.
// - FSM, edge detect, compare stage and error registers live in the top.
// TESTING
// - Fill: reset, listen=1, 8 strobes with din=16'h1000+i -> buf_full=1 after 8th, wr_count=8, state FULL, overflow=0.
// - Clean read: after fill, readPtr 0->1..7 with dout = 16'h1000+ptr one clk later -> mismatch never pulses, err_count=0.
// - Corrupt read: readPtr=3, dout=16'hDEAD -> mismatch 1 clk, err_ptr=3, err_exp=16'h1003, err_act=16'hDEAD, err_count=1.
// - Overflow and saturation:
//   - 9th strobe in FULL -> overflow=1, shadow[0] still 16'h1000;
//   - 300 forced mismatches (ERR_W=8) -> err_count=255.
// - Restart: listen re-pulse in CHECK, then 8 strobes din=16'h2000+i -> new compares use 16'h2000 data; err_count retained.
// - Reset mid-capture: after 4 strobes assert reset 1 clk -> all outputs 0, state IDLE; strobes without listen do not change wr_count.

Source files
------------

// File: rtl/ring_buffer_checker_pkg.sv
// Shared types and constants for the ring buffer checker.
package ring_buffer_checker_pkg;

    // ARMED and CAPTURE share ARMED_CAP; wr_count == 0 means still armed.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED_CAP = 2'd1,
        FULL      = 2'd2,
        CHECK     = 2'd3
    } rbc_state_t;

    localparam int ERR_W_DEF = 8;

    // All-ones value of a w-bit counter, used as the saturation ceiling.
    function automatic int unsigned err_sat(input int w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned ERR_SAT = err_sat(ERR_W_DEF);

endpackage

// File: rtl/rbc_shadow_mem.sv
// Shadow copy of the ring buffer: register array, one synchronous write
// port, one combinational read port. Contents are not reset.
module rbc_shadow_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Capture write data into the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ring_buffer_checker.sv
// Ring buffer checker: shadows strobed writes, then compares every read
// (readPtr change, dout one clock later) against the shadow and records
// the most recent mismatch in registered status outputs.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for listen
// ARMED_CAP | capturing writes; wr_count == 0 means armed, nothing captured
// FULL      | DEPTH entries captured, waiting for the first read
// CHECK     | comparing every readPtr change against the shadow
module ring_buffer_checker
    import ring_buffer_checker_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int ERR_W = ERR_W_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             listen,
    input  logic             strobe,
    input  logic [WIDTH-1:0] din,
    input  logic [PTR_W-1:0] readPtr,
    input  logic [WIDTH-1:0] dout,
    output logic [1:0]       state_o,
    output logic [PTR_W:0]   wr_count,
    output logic             buf_full,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [PTR_W-1:0] err_ptr,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_act,
    output logic             overflow
);

    localparam logic [PTR_W:0]   LAST_IDX = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX  =
        ERR_W'((ERR_W == ERR_W_DEF) ? ERR_SAT : err_sat(ERR_W));

    rbc_state_t       state, state_nxt;
    logic [PTR_W:0]   wr_count_nxt;
    logic             strobe_q, listen_q;
    logic [PTR_W-1:0] readPtr_q;
    logic             cmp_pend;
    logic [PTR_W-1:0] cmp_ptr;

    logic             strobe_rise, listen_rise, rdchg;
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [WIDTH-1:0] exp_data;
    logic             overflow_set, sched_cmp, cmp_fail;

    assign strobe_rise = strobe & ~strobe_q;
    assign listen_rise = listen & ~listen_q;
    assign rdchg       = (readPtr != readPtr_q) & ~reset;

    rbc_shadow_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_shadow (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (din),
        .raddr (cmp_ptr),
        .rdata (exp_data)
    );

    // The compare stage sees dout one clock after the pointer moved.
    assign cmp_fail = cmp_pend & (dout != exp_data);

    // Next-state, capture write and compare scheduling.
    always_comb begin
        state_nxt    = state;
        wr_count_nxt = wr_count;
        mem_we       = 1'b0;
        mem_waddr    = wr_count[PTR_W-1:0];
        overflow_set = 1'b0;
        sched_cmp    = 1'b0;
        case (state)
            IDLE: begin
                if (listen) begin
                    state_nxt    = ARMED_CAP;
                    wr_count_nxt = '0;
                end
            end
            ARMED_CAP: begin
                if (strobe_rise) begin
                    mem_we       = 1'b1;
                    wr_count_nxt = wr_count + 1'b1;
                    if (wr_count == LAST_IDX) begin
                        state_nxt = FULL;
                    end
                end
            end
            FULL, CHECK: begin
                if (listen_rise) begin
                    // Restart wins over a coincident strobe, which becomes entry 0.
                    state_nxt = ARMED_CAP;
                    mem_waddr = '0;
                    if (strobe_rise) begin
                        mem_we       = 1'b1;
                        wr_count_nxt = (PTR_W + 1)'(1);
                    end else begin
                        wr_count_nxt = '0;
                    end
                end else begin
                    if (strobe_rise) begin
                        overflow_set = 1'b1;
                    end
                    if (rdchg) begin
                        sched_cmp = 1'b1;
                        state_nxt = CHECK;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, edge-detect history, compare pipeline and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_count  <= '0;
            buf_full  <= 1'b0;
            strobe_q  <= 1'b0;
            listen_q  <= 1'b0;
            readPtr_q <= '0;
            cmp_pend  <= 1'b0;
            cmp_ptr   <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
            err_ptr   <= '0;
            err_exp   <= '0;
            err_act   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_count  <= wr_count_nxt;
            buf_full  <= (wr_count_nxt == FULL_CNT);
            strobe_q  <= strobe;
            listen_q  <= listen;
            readPtr_q <= readPtr;
            cmp_pend  <= sched_cmp;
            if (sched_cmp) begin
                cmp_ptr <= readPtr;
            end
            mismatch <= cmp_fail;
            if (cmp_fail) begin
                err_ptr <= cmp_ptr;
                err_exp <= exp_data;
                err_act <= dout;
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + 1'b1;
                end
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ring_buffer_checker.sv
// Self-checking bench for ring_buffer_checker with a queue/array model.
module tb_ring_buffer_checker;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic        clk = 1'b0;
    logic        reset, listen, strobe;
    logic [15:0] din, dout;
    logic [2:0]  readPtr;
    logic [1:0]  state_o;
    logic [3:0]  wr_count;
    logic        buf_full, mismatch, overflow;
    logic [7:0]  err_count;
    logic [2:0]  err_ptr;
    logic [15:0] err_exp, err_act;

    int errors = 0;
    int checks = 0;

    // reference model: what the shadow should hold and the last error seen
    logic [15:0] shadow_m [8];
    int          m_errs;
    logic [2:0]  m_eptr;
    logic [15:0] m_eexp, m_eact;

    ring_buffer_checker #(.WIDTH(16), .DEPTH(8), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .listen(listen), .strobe(strobe), .din(din),
        .readPtr(readPtr), .dout(dout), .state_o(state_o), .wr_count(wr_count),
        .buf_full(buf_full), .mismatch(mismatch), .err_count(err_count),
        .err_ptr(err_ptr), .err_exp(err_exp), .err_act(err_act), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        m_errs = 0;
        m_eptr = '0;
        m_eexp = '0;
        m_eact = '0;
    endtask

    task automatic do_strobe(input logic [15:0] d);
        din    = d;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
    endtask

    function automatic logic [2:0] rand_ptr(input logic [2:0] prev);
        logic [2:0] step;
        step = 3'($urandom_range(1, 7));
        return prev + step;
    endfunction

    // Drive a pointer sequence with dout trailing by one clock; check each compare.
    task automatic run_reads(input logic [2:0] ptrs[$], input logic [15:0] douts[$]);
        int   n;
        logic exp_fail;
        n = ptrs.size();
        for (int k = 0; k <= n; k++) begin
            if (k < n) readPtr = ptrs[k];
            if (k >= 1) dout = douts[k-1];
            tick();
            if (k >= 1) begin
                exp_fail = (douts[k-1] !== shadow_m[ptrs[k-1]]);
                if (exp_fail) begin
                    if (m_errs < 255) m_errs++;
                    m_eptr = ptrs[k-1];
                    m_eexp = shadow_m[ptrs[k-1]];
                    m_eact = douts[k-1];
                end
                checks++;
                if (mismatch !== exp_fail) begin
                    errors++;
                    $display("FAIL mismatch read %0d ptr=%0d: got %b want %b", k-1, ptrs[k-1], mismatch, exp_fail);
                end
                checks++;
                if (err_count !== 8'(m_errs)) begin
                    errors++;
                    $display("FAIL err_count read %0d: got %0d want %0d", k-1, err_count, m_errs);
                end
                checks++;
                if ({err_ptr, err_exp, err_act} !== {m_eptr, m_eexp, m_eact}) begin
                    errors++;
                    $display("FAIL err_regs read %0d: got ptr=%0d exp=%h act=%h want ptr=%0d exp=%h act=%h",
                             k-1, err_ptr, err_exp, err_act, m_eptr, m_eexp, m_eact);
                end
            end
        end
        tick();
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_tail: got %b want 0", mismatch);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; listen = 1'b0; strobe = 1'b0;
        din = '0; dout = '0; readPtr = '0;
        model_clear();
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({state_o, wr_count, buf_full, mismatch, err_count, err_ptr, err_exp, err_act, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got state=%0d wr=%0d full=%b mm=%b ec=%0d ep=%0d ee=%h ea=%h ov=%b want all 0",
                     state_o, wr_count, buf_full, mismatch, err_count, err_ptr, err_exp, err_act, overflow);
        end
    endtask

    task automatic test_fill;
        listen = 1'b1;
        tick();
        checks++;
        if (state_o !== S_ARM || wr_count !== 4'd0) begin
            errors++;
            $display("FAIL armed: got state=%0d wr=%0d want state=1 wr=0", state_o, wr_count);
        end
        for (int i = 0; i < 8; i++) begin
            shadow_m[i] = 16'h1000 + 16'(i);
            do_strobe(shadow_m[i]);
            checks++;
            if (wr_count !== 4'(i + 1)) begin
                errors++;
                $display("FAIL fill_wr_count %0d: got %0d want %0d", i, wr_count, i + 1);
            end
            checks++;
            if (buf_full !== (i == 7)) begin
                errors++;
                $display("FAIL fill_buf_full %0d: got %b want %b", i, buf_full, (i == 7));
            end
        end
        checks++;
        if (state_o !== S_FULL || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_end: got state=%0d ov=%b want state=2 ov=0", state_o, overflow);
        end
    endtask

    task automatic test_clean_read;
        logic [2:0]  p[$];
        logic [15:0] d[$];
        for (int i = 1; i < 8; i++) begin
            p.push_back(3'(i));
            d.push_back(shadow_m[i]);
        end
        run_reads(p, d);
        checks++;
        if (state_o !== S_CHECK || err_count !== 8'd0) begin
            errors++;
            $display("FAIL clean_read_end: got state=%0d ec=%0d want state=3 ec=0", state_o, err_count);
        end
    endtask

    task automatic test_corrupt_read;
        logic [2:0]  p[$];
        logic [15:0] d[$];
        p.push_back(3'd3);
        d.push_back(16'hDEAD);
        run_reads(p, d);
        checks++;
        if (err_ptr !== 3'd3 || err_exp !== 16'h1003 || err_act !== 16'hDEAD || err_count !== 8'd1) begin
            errors++;
            $display("FAIL corrupt_read: got ptr=%0d exp=%h act=%h ec=%0d want 3 1003 dead 1",
                     err_ptr, err_exp, err_act, err_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  p[$];
        logic [15:0] d[$];
        logic [2:0]  last;
        last = readPtr;
        for (int i = 0; i < 24; i++) begin
            last = rand_ptr(last);
            p.push_back(last);
            if ($urandom_range(0, 99) < 40)
                d.push_back(shadow_m[last] ^ 16'($urandom_range(1, 65535)));
            else
                d.push_back(shadow_m[last]);
        end
        run_reads(p, d);
    endtask

    task automatic test_overflow;
        logic [2:0]  p[$];
        logic [15:0] d[$];
        do_strobe(16'($urandom));
        checks++;
        if (overflow !== 1'b1 || wr_count !== 4'd8 || state_o !== S_CHECK || buf_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got ov=%b wr=%0d state=%0d full=%b want 1 8 3 1",
                     overflow, wr_count, state_o, buf_full);
        end
        if (readPtr == 3'd0) begin
            p.push_back(3'd5);
            d.push_back(shadow_m[5]);
        end
        p.push_back(3'd0);
        d.push_back(16'h1000);
        run_reads(p, d);
    endtask

    task automatic test_saturation;
        logic [2:0]  p[$];
        logic [15:0] d[$];
        logic [2:0]  last;
        last = readPtr;
        for (int i = 0; i < 300; i++) begin
            last = rand_ptr(last);
            p.push_back(last);
            d.push_back(~shadow_m[last]);
        end
        run_reads(p, d);
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation: got %0d want 255", err_count);
        end
    endtask

    task automatic test_restart;
        logic [2:0]  p[$];
        logic [15:0] d[$];
        listen = 1'b0;
        tick();
        checks++;
        if (state_o !== S_CHECK) begin
            errors++;
            $display("FAIL listen_drop: got state=%0d want 3", state_o);
        end
        listen = 1'b1;
        tick();
        checks++;
        if (state_o !== S_ARM || wr_count !== 4'd0 || err_count !== 8'd255 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL restart: got state=%0d wr=%0d ec=%0d ov=%b want 1 0 255 1",
                     state_o, wr_count, err_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            shadow_m[i] = 16'h2000 + 16'(i);
            do_strobe(shadow_m[i]);
        end
        checks++;
        if (state_o !== S_FULL || wr_count !== 4'd8) begin
            errors++;
            $display("FAIL refill: got state=%0d wr=%0d want 2 8", state_o, wr_count);
        end
        for (int i = 0; i < 8; i++) begin
            p.push_back(3'(i) + readPtr + 3'd1);
            d.push_back(shadow_m[3'(i) + readPtr + 3'd1]);
        end
        p.push_back(rand_ptr(p[$]));
        d.push_back(16'h0BAD);
        run_reads(p, d);
        checks++;
        if (err_exp !== (16'h2000 + 16'(err_ptr)) || err_count !== 8'd255) begin
            errors++;
            $display("FAIL restart_data: got exp=%h ec=%0d want %h 255", err_exp, err_count, 16'h2000 + 16'(err_ptr));
        end
    endtask

    task automatic test_restart_with_strobe;
        logic [2:0]  p[$];
        logic [15:0] d[$];
        listen = 1'b0;
        tick();
        shadow_m[0] = 16'($urandom);
        listen = 1'b1;
        strobe = 1'b1;
        din    = shadow_m[0];
        tick();
        strobe = 1'b0;
        tick();
        checks++;
        if (state_o !== S_ARM || wr_count !== 4'd1) begin
            errors++;
            $display("FAIL restart_strobe: got state=%0d wr=%0d want 1 1", state_o, wr_count);
        end
        for (int i = 1; i < 8; i++) begin
            shadow_m[i] = 16'($urandom);
            do_strobe(shadow_m[i]);
        end
        if (readPtr == 3'd0) begin
            p.push_back(3'd2);
            d.push_back(shadow_m[2]);
        end
        p.push_back(3'd0);
        d.push_back(shadow_m[0]);
        p.push_back(3'd1);
        d.push_back(shadow_m[1]);
        run_reads(p, d);
    endtask

    task automatic test_reset_mid_capture;
        listen = 1'b0;
        tick();
        listen = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) do_strobe(16'($urandom));
        checks++;
        if (state_o !== S_ARM || wr_count !== 4'd4) begin
            errors++;
            $display("FAIL mid_capture: got state=%0d wr=%0d want 1 4", state_o, wr_count);
        end
        reset  = 1'b1;
        listen = 1'b0;
        tick();
        reset = 1'b0;
        model_clear();
        checks++;
        if ({state_o, wr_count, buf_full, mismatch, err_count, err_ptr, err_exp, err_act, overflow} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got state=%0d wr=%0d full=%b mm=%b ec=%0d ep=%0d ee=%h ea=%h ov=%b want all 0",
                     state_o, wr_count, buf_full, mismatch, err_count, err_ptr, err_exp, err_act, overflow);
        end
        for (int i = 0; i < 3; i++) do_strobe(16'($urandom));
        readPtr = rand_ptr(readPtr);
        tick();
        tick();
        checks++;
        if (wr_count !== 4'd0 || state_o !== S_IDLE || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL idle_strobes: got wr=%0d state=%0d mm=%b want 0 0 0", wr_count, state_o, mismatch);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_clean_read();
        test_corrupt_read();
        test_back_to_back();
        test_overflow();
        test_saturation();
        test_restart();
        test_restart_with_strobe();
        test_reset_mid_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
